// File: rtl/rgb2gray_dma.sv
// rgb2gray_dma: OBI DMA converting RGBA pixels to packed 8-bit luminance words.
// Define RGB2GRAY_PERF_EN to add a saturating BUSY-cycle counter at register offset 6.

package rgb2gray_dma_pkg;
    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;

    typedef struct packed {
        logic                    req;
        logic [ObiAddrWidth-1:0] addr;
        logic                    we;
        logic [3:0]              be;
        logic [ObiDataWidth-1:0] wdata;
    } sbr_obi_req_t;

    typedef struct packed {
        logic                    gnt;
        logic                    rvalid;
        logic [ObiDataWidth-1:0] rdata;
        logic                    err;
    } sbr_obi_rsp_t;

    typedef sbr_obi_req_t mgr_obi_req_t;
    typedef sbr_obi_rsp_t mgr_obi_rsp_t;
endpackage

module rgb2gray_dma
    import rgb2gray_dma_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntWidth  = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    output sbr_obi_req_t obi_mgr_req_o,
    input  sbr_obi_rsp_t obi_mgr_rsp_i,
    input  mgr_obi_req_t obi_sbr_req_i,
    output mgr_obi_rsp_t obi_sbr_rsp_o,
    output logic         interrupt_o
);

    // IDLE wait START | RD_REQ/RD_WAIT fetch one pixel | WR_REQ/WR_WAIT store packed word | FINISH set DONE
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] src_q, dst_q, mgr_addr;
    logic [CntWidth-1:0]  num_q, pix_cnt_q, wr_cnt;
    logic                 irq_en_q, done_q, irq_q, rvalid_q;
    logic [DataWidth-1:0] pack_q, rdata_q, rdata_d;
    logic [3:0]           reg_idx;
    logic                 sbr_we, cfg_we, busy, start;
    logic [1:0]           lane;
    logic                 last_lane, last_pix, all_done;
    logic [7:0]           px_r, px_g, px_b, gray;
    logic [15:0]          gray_sum;
    logic                 unused_sig;

    assign busy    = (state_q != IDLE);
    assign reg_idx = obi_sbr_req_i.addr[5:2];
    assign sbr_we  = obi_sbr_req_i.req & obi_sbr_req_i.we;
    assign cfg_we  = sbr_we & ~busy;
    assign start   = cfg_we && (reg_idx == 4'd3) && obi_sbr_req_i.wdata[0];

    assign px_r     = obi_mgr_rsp_i.rdata[7:0];
    assign px_g     = obi_mgr_rsp_i.rdata[15:8];
    assign px_b     = obi_mgr_rsp_i.rdata[23:16];
    assign gray_sum = 16'd77 * {8'd0, px_r} + 16'd150 * {8'd0, px_g} + 16'd29 * {8'd0, px_b};
    assign gray     = gray_sum[15:8];

    assign lane      = pix_cnt_q[1:0];
    assign last_lane = (lane == 2'd3);
    assign last_pix  = ((pix_cnt_q + CntWidth'(1)) == num_q);
    assign all_done  = (pix_cnt_q == num_q);
    assign wr_cnt    = pix_cnt_q - CntWidth'(1);

    assign unused_sig = ^{obi_sbr_req_i.addr[31:6], obi_sbr_req_i.addr[1:0], obi_sbr_req_i.be,
                          obi_mgr_rsp_i.err, obi_mgr_rsp_i.rdata[31:24], gray_sum[7:0]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_q == '0) ? FINISH : RD_REQ;
            RD_REQ:  if (obi_mgr_rsp_i.gnt) state_d = RD_WAIT;
            RD_WAIT: if (obi_mgr_rsp_i.rvalid) state_d = (last_lane || last_pix) ? WR_REQ : RD_REQ;
            WR_REQ:  if (obi_mgr_rsp_i.gnt) state_d = WR_WAIT;
            WR_WAIT: if (obi_mgr_rsp_i.rvalid) state_d = all_done ? FINISH : RD_REQ;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // lane holds the number of valid bytes in the final word (0 means all four)
    always_comb begin
        obi_mgr_req_o = '0;
        mgr_addr      = '0;
        case (state_q)
            RD_REQ: begin
                obi_mgr_req_o.req = 1'b1;
                obi_mgr_req_o.be  = 4'hF;
                mgr_addr          = src_q + AddrWidth'({pix_cnt_q, 2'b00});
            end
            WR_REQ: begin
                obi_mgr_req_o.req   = 1'b1;
                obi_mgr_req_o.we    = 1'b1;
                obi_mgr_req_o.wdata = ObiDataWidth'(pack_q);
                mgr_addr            = dst_q + AddrWidth'({wr_cnt[CntWidth-1:2], 2'b00});
                case (lane)
                    2'd1:    obi_mgr_req_o.be = 4'b0001;
                    2'd2:    obi_mgr_req_o.be = 4'b0011;
                    2'd3:    obi_mgr_req_o.be = 4'b0111;
                    default: obi_mgr_req_o.be = 4'b1111;
                endcase
            end
            default: ;
        endcase
        obi_mgr_req_o.addr = ObiAddrWidth'(mgr_addr);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pix_cnt_q <= '0;
            pack_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    pix_cnt_q <= '0;
                    pack_q    <= '0;
                end
                RD_WAIT: if (obi_mgr_rsp_i.rvalid) begin
                    pack_q[{lane, 3'b000} +: 8] <= gray;
                    pix_cnt_q                   <= pix_cnt_q + CntWidth'(1);
                end
                WR_WAIT: if (obi_mgr_rsp_i.rvalid) pack_q <= '0;
                default: ;
            endcase
        end
    end

`ifdef RGB2GRAY_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)                        perf_q <= '0;
        else if (start)                     perf_q <= '0;
        else if (busy && (perf_q != '1))    perf_q <= perf_q + 32'd1;
    end
`endif

    always_comb begin
        rdata_d = '0;
        case (reg_idx)
            4'd0: rdata_d = DataWidth'(src_q);
            4'd1: rdata_d = DataWidth'(dst_q);
            4'd2: rdata_d = DataWidth'(num_q);
            4'd4: rdata_d = DataWidth'({done_q, busy});
            4'd5: rdata_d = DataWidth'(irq_en_q);
`ifdef RGB2GRAY_PERF_EN
            4'd6: rdata_d = DataWidth'(perf_q);
`endif
            default: rdata_d = '0;
        endcase
    end

    // FINISH setting DONE takes priority over a same-cycle write-1-to-clear
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            src_q    <= '0;
            dst_q    <= '0;
            num_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (cfg_we) begin
                case (reg_idx)
                    4'd0:    src_q <= AddrWidth'(obi_sbr_req_i.wdata);
                    4'd1:    dst_q <= AddrWidth'(obi_sbr_req_i.wdata);
                    4'd2:    num_q <= obi_sbr_req_i.wdata[CntWidth-1:0];
                    default: ;
                endcase
            end
            if (sbr_we && (reg_idx == 4'd5)) irq_en_q <= obi_sbr_req_i.wdata[0];
            if (state_q == FINISH)
                done_q <= 1'b1;
            else if (sbr_we && (reg_idx == 4'd4) && obi_sbr_req_i.wdata[1])
                done_q <= 1'b0;
            irq_q    <= done_q & irq_en_q;
            rvalid_q <= obi_sbr_req_i.req;
            if (obi_sbr_req_i.req) rdata_q <= rdata_d;
        end
    end

    assign obi_sbr_rsp_o.gnt    = obi_sbr_req_i.req;
    assign obi_sbr_rsp_o.rvalid = rvalid_q;
    assign obi_sbr_rsp_o.rdata  = ObiDataWidth'(rdata_q);
    assign obi_sbr_rsp_o.err    = 1'b0;
    assign interrupt_o          = irq_q;

endmodule
